// File: rtl/regfile_write_arbiter.sv
// Three-way round-robin write arbiter in front of the register file write port.
// One registered write per cycle; writes to r0 consume a grant but never assert the enable.
module regfile_write_arbiter #(
    parameter  int DATA_W = 32,
    localparam int NREQ   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [5*NREQ-1:0]      req_rd,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   stall,
    output logic                   ctrl_writeEnable,
    output logic [4:0]             ctrl_writeReg,
    output logic [DATA_W-1:0]      data_writeReg,
    output logic [1:0]             grant_id,
    output logic [15:0]            write_count
);

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              we_q, we_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gid_q, gid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [1:0]        cand1, cand2;
    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
    always_comb begin
        cand1     = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
        cand2     = (rr_ptr_q == 2'd0) ? 2'd2 : rr_ptr_q - 2'd1;
        grant_any = 1'b0;
        grant_idx = rr_ptr_q;
        if (!reset && !stall) begin
            if (req_valid[rr_ptr_q]) begin
                grant_any = 1'b1;
                grant_idx = rr_ptr_q;
            end else if (req_valid[cand1]) begin
                grant_any = 1'b1;
                grant_idx = cand1;
            end else if (req_valid[cand2]) begin
                grant_any = 1'b1;
                grant_idx = cand2;
            end
        end
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Only the granted requester's fields reach the output register
    always_comb begin
        case (grant_idx)
            2'd0: begin
                sel_rd   = req_rd[4:0];
                sel_data = req_data[DATA_W-1:0];
            end
            2'd1: begin
                sel_rd   = req_rd[9:5];
                sel_data = req_data[2*DATA_W-1:DATA_W];
            end
            default: begin
                sel_rd   = req_rd[14:10];
                sel_data = req_data[3*DATA_W-1:2*DATA_W];
            end
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        gid_d    = 2'd3;
        cnt_d    = cnt_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            gid_d    = grant_idx;
            if (sel_rd != 5'd0) begin
                we_d    = 1'b1;
                wreg_d  = sel_rd;
                wdata_d = sel_data;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= 2'd0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            gid_q    <= 2'd3;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign grant_id         = gid_q;
    assign write_count      = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, counter saturation run,
// and randomized traffic against a round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [14:0]     req_rd;
    logic [3*DW-1:0] req_data;
    logic            stall;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [DW-1:0]   data_writeReg;
    logic [1:0]      grant_id;
    logic [15:0]     write_count;

    regfile_write_arbiter #(.DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_rd           (req_rd),
        .req_data         (req_data),
        .stall            (stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .grant_id         (grant_id),
        .write_count      (write_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            rst;
        logic            stl;
        logic [2:0]      vld;
        logic [14:0]     rd;
        logic [3*DW-1:0] data;
        logic [2:0]      e_rdy;
        logic            e_we;
        logic [4:0]      e_reg;
        logic [DW-1:0]   e_data;
        logic [1:0]      e_gid;
        logic [15:0]     e_cnt;
    } vec_t;

    localparam int NV = 19;
    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h2222_0001;
    localparam logic [DW-1:0] D2 = 32'h3333_0002;
    localparam logic [14:0]   RD321 = {5'd3, 5'd2, 5'd1};
    localparam logic [3*DW-1:0] DALL = {D2, D1, D0};

    vec_t vecs [NV];

    // Reference model state
    int            m_ptr;
    logic          m_we;
    logic [4:0]    m_reg;
    logic [DW-1:0] m_data;
    int            m_gid;
    int            m_cnt;
    bit            m_known;

    function automatic int model_pick(input int ptr, input logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_cycle();
        int g;
        logic [4:0] rd;
        logic [DW-1:0] dt;
        #1;
        g = (reset || stall) ? -1 : model_pick(m_ptr, req_valid);
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        @(posedge clock);
        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
            m_gid = 3; m_cnt = 0; m_known = 1'b1;
        end else if (g >= 0) begin
            rd    = 5'((req_rd >> (5 * g)) & 15'h1f);
            dt    = DW'(req_data >> (DW * g));
            m_ptr = (g + 1) % 3;
            m_gid = g;
            if (rd != 0) begin
                m_we = 1'b1; m_reg = rd; m_data = dt; m_known = 1'b1;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end else begin
                m_we = 1'b0; m_known = 1'b0;
            end
        end else begin
            m_we = 1'b0; m_gid = 3;
        end
        #1;
        chk("rnd_we", 64'(ctrl_writeEnable), 64'(m_we));
        chk("rnd_gid", 64'(grant_id), 64'(m_gid));
        chk("rnd_cnt", 64'(write_count), 64'(m_cnt));
        if (m_known) begin
            chk("rnd_reg", 64'(ctrl_writeReg), 64'(m_reg));
            chk("rnd_data", 64'(data_writeReg), 64'(m_data));
        end
    endtask

    initial begin
        //          rst   stl   vld     rd                  data                       e_rdy   we    reg   e_data       gid   cnt
        vecs[0]  = '{1'b1, 1'b0, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd0, '0,          2'd3, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 3'b010, 15'(5 << 5),       {D2, 32'hDEADBEEF, D0},    3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 3'b000, 15'd0,             '0,                        3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd3, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 15'd0,             '0,                        3'b000, 1'b0, 5'd0, '0,          2'd3, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b001, 1'b1, 5'd1, D0,          2'd0, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b010, 1'b1, 5'd2, D1,          2'd1, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b100, 1'b1, 5'd3, D2,          2'd2, 16'd3};
        vecs[7]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b001, 1'b1, 5'd1, D0,          2'd0, 16'd4};
        vecs[8]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b010, 1'b1, 5'd2, D1,          2'd1, 16'd5};
        vecs[9]  = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b100, 1'b1, 5'd3, D2,          2'd2, 16'd6};
        vecs[10] = '{1'b0, 1'b0, 3'b001, {5'd3, 5'd2, 5'd0}, {D2, D1, 32'h1234},       3'b001, 1'b0, 5'd3, D2,          2'd0, 16'd6};
        vecs[11] = '{1'b0, 1'b1, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd3, D2,          2'd3, 16'd6};
        vecs[12] = '{1'b0, 1'b1, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd3, D2,          2'd3, 16'd6};
        vecs[13] = '{1'b0, 1'b1, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd3, D2,          2'd3, 16'd6};
        vecs[14] = '{1'b0, 1'b1, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd3, D2,          2'd3, 16'd6};
        vecs[15] = '{1'b0, 1'b0, 3'b111, RD321,             DALL,                      3'b010, 1'b1, 5'd2, D1,          2'd1, 16'd7};
        vecs[16] = '{1'b0, 1'b0, 3'b100, RD321,             DALL,                      3'b100, 1'b1, 5'd3, D2,          2'd2, 16'd8};
        vecs[17] = '{1'b1, 1'b0, 3'b111, RD321,             DALL,                      3'b000, 1'b0, 5'd0, '0,          2'd3, 16'd0};
        vecs[18] = '{1'b0, 1'b0, 3'b100, RD321,             DALL,                      3'b100, 1'b1, 5'd3, D2,          2'd2, 16'd1};

        reset = 1'b1; stall = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; stall = vecs[i].stl; req_valid = vecs[i].vld;
            req_rd = vecs[i].rd; req_data = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_we", i), 64'(ctrl_writeEnable), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_reg", i), 64'(ctrl_writeReg), 64'(vecs[i].e_reg));
            chk($sformatf("v%0d_data", i), 64'(data_writeReg), 64'(vecs[i].e_data));
            chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(vecs[i].e_gid));
            chk($sformatf("v%0d_cnt", i), 64'(write_count), 64'(vecs[i].e_cnt));
        end

        // Saturation: one write per cycle from requester 0 to r7
        reset = 1'b1; stall = 1'b0; req_valid = '0;
        @(posedge clock); #1;
        reset = 1'b0; req_valid = 3'b001; req_rd = 15'd7; req_data = DALL;
        for (int i = 1; i <= 65536; i++) begin
            @(posedge clock); #1;
            if (i == 1000) chk("sat_1000", 64'(write_count), 64'd1000);
            if (i == 65534) chk("sat_65534", 64'(write_count), 64'hFFFE);
            if (i == 65535) chk("sat_65535", 64'(write_count), 64'hFFFF);
        end
        chk("sat_65536", 64'(write_count), 64'hFFFF);
        chk("sat_we", 64'(ctrl_writeEnable), 64'd1);
        @(posedge clock); #1;
        chk("sat_hold", 64'(write_count), 64'hFFFF);

        // Randomized traffic against the reference model, starting from reset
        reset = 1'b1; stall = 1'b0; req_valid = '0;
        model_cycle();
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            req_valid = 3'($urandom);
            req_rd    = 15'($urandom);
            if ($urandom_range(0, 7) == 0) req_rd[4:0] = 5'd0;
            req_data  = {$urandom, $urandom, $urandom};
            model_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
